collision_sequencer: RTL and testbench



---
 rtl/collision_sequencer_if.sv | 24 ++
 rtl/collision_sequencer.sv | 276 +++++++++++++++++++++++++++
 tb/tb_collision_sequencer.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/collision_sequencer_if.sv
// Custom-instruction bus between the collision-search initiator and its responder.
//   master: drives ci_start/ci_n/ci_dataa/ci_datab, samples ci_done/ci_result
//   slave : samples the call signals, drives ci_done/ci_result
interface collision_sequencer_if;
  localparam int unsigned N_W    = 3;
  localparam int unsigned DATA_W = 32;

  logic              ci_start;
  logic [N_W-1:0]    ci_n;
  logic [DATA_W-1:0] ci_dataa;
  logic [DATA_W-1:0] ci_datab;
  logic              ci_done;
  logic [DATA_W-1:0] ci_result;

  modport master (
    output ci_start, ci_n, ci_dataa, ci_datab,
    input  ci_done, ci_result
  );

  modport slave (
    input  ci_start, ci_n, ci_dataa, ci_datab,
    output ci_done, ci_result
  );
endinterface

// File: rtl/collision_sequencer.sv
// Hardware initiator for the collision-search custom instruction: loads a
// 16-word base message as 8 operand pairs (n=0), starts the search (n=1),
// polls completion (n=3), fetches the collision (n=2) and digest count (n=4),
// then reports one result record.
// Ports:
//   wClock, reset        clock, asynchronous active-high reset
//   go, target           run request (IDLE only) and latched collision target
//   msg_word/valid/ready base-message word stream
//   ci                   custom-instruction bus (master side)
//   busy, result_valid   run in progress, one-cycle end-of-run pulse
//   found/timeout/error  run outcome flags
//   collision, digests   n=2 and n=4 results
module collision_sequencer #(
  parameter int unsigned POLL_GAP     = 16,
  parameter int unsigned MAX_POLLS    = 0,
  parameter int unsigned DONE_TIMEOUT = 255
) (
  input  logic                  wClock,
  input  logic                  reset,
  input  logic                  go,
  input  logic [4:0]            target,
  input  logic [31:0]           msg_word,
  input  logic                  msg_valid,
  output logic                  msg_ready,
  collision_sequencer_if.master ci,
  output logic                  busy,
  output logic                  result_valid,
  output logic                  found,
  output logic                  timeout,
  output logic                  error,
  output logic [31:0]           collision,
  output logic [31:0]           digests
);

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned TGT_W     = 5;
  localparam int unsigned N_W       = 3;
  localparam int unsigned CNT_W     = 32;
  localparam int unsigned PAIR_W    = 3;
  localparam int unsigned NUM_PAIRS = 8;

  localparam logic [N_W-1:0] N_LOAD  = N_W'(0);
  localparam logic [N_W-1:0] N_START = N_W'(1);
  localparam logic [N_W-1:0] N_FETCH = N_W'(2);
  localparam logic [N_W-1:0] N_POLL  = N_W'(3);
  localparam logic [N_W-1:0] N_COUNT = N_W'(4);

  typedef enum logic [3:0] {
    IDLE, GET_A, GET_B, CALL_LOAD, CALL_START,
    GAP, CALL_POLL, CALL_FETCH, CALL_COUNT, REPORT
  } state_t;

  state_t              state_q, state_d;
  logic [PAIR_W-1:0]   pair_q, pair_d;
  logic [CNT_W-1:0]    poll_q, poll_d;
  logic [CNT_W-1:0]    gap_q, gap_d;
  logic [CNT_W-1:0]    wait_q, wait_d;
  logic [TGT_W-1:0]    target_q, target_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic                ci_start_q, ci_start_d;
  logic [N_W-1:0]      ci_n_q, ci_n_d;
  logic [DATA_W-1:0]   ci_dataa_q, ci_dataa_d;
  logic [DATA_W-1:0]   ci_datab_q, ci_datab_d;
  logic                msg_ready_q, msg_ready_d;
  logic                busy_q, busy_d;
  logic                result_valid_q, result_valid_d;
  logic                found_q, found_d;
  logic                timeout_q, timeout_d;
  logic                error_q, error_d;
  logic [DATA_W-1:0]   collision_q, collision_d;
  logic [DATA_W-1:0]   digests_q, digests_d;
  logic                call_active_c;

  assign call_active_c = (state_q == CALL_LOAD) || (state_q == CALL_START) ||
                         (state_q == CALL_POLL) || (state_q == CALL_FETCH) ||
                         (state_q == CALL_COUNT);

  // State register
  always_ff @(posedge wClock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      pair_q         <= '0;
      poll_q         <= '0;
      gap_q          <= '0;
      wait_q         <= '0;
      target_q       <= '0;
      a_q            <= '0;
      ci_start_q     <= 1'b0;
      ci_n_q         <= '0;
      ci_dataa_q     <= '0;
      ci_datab_q     <= '0;
      msg_ready_q    <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      found_q        <= 1'b0;
      timeout_q      <= 1'b0;
      error_q        <= 1'b0;
      collision_q    <= '0;
      digests_q      <= '0;
    end else begin
      state_q        <= state_d;
      pair_q         <= pair_d;
      poll_q         <= poll_d;
      gap_q          <= gap_d;
      wait_q         <= wait_d;
      target_q       <= target_d;
      a_q            <= a_d;
      ci_start_q     <= ci_start_d;
      ci_n_q         <= ci_n_d;
      ci_dataa_q     <= ci_dataa_d;
      ci_datab_q     <= ci_datab_d;
      msg_ready_q    <= msg_ready_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      found_q        <= found_d;
      timeout_q      <= timeout_d;
      error_q        <= error_d;
      collision_q    <= collision_d;
      digests_q      <= digests_d;
    end
  end

  // Next-state and registered-output logic; a call is launched by raising
  // ci_start_d together with its operands so they appear on the state's first cycle.
  always_comb begin
    state_d        = state_q;
    pair_d         = pair_q;
    poll_d         = poll_q;
    gap_d          = gap_q;
    wait_d         = wait_q;
    target_d       = target_q;
    a_d            = a_q;
    ci_start_d     = 1'b0;
    ci_n_d         = ci_n_q;
    ci_dataa_d     = ci_dataa_q;
    ci_datab_d     = ci_datab_q;
    busy_d         = busy_q;
    result_valid_d = 1'b0;
    found_d        = found_q;
    timeout_d      = timeout_q;
    error_d        = error_q;
    collision_d    = collision_q;
    digests_d      = digests_q;

    unique case (state_q)
      IDLE: begin
        if (go) begin
          target_d    = target;
          found_d     = 1'b0;
          timeout_d   = 1'b0;
          error_d     = 1'b0;
          collision_d = '0;
          digests_d   = '0;
          busy_d      = 1'b1;
          pair_d      = '0;
          poll_d      = '0;
          state_d     = GET_A;
        end
      end
      GET_A: begin
        if (msg_valid && msg_ready_q) begin
          a_d     = msg_word;
          state_d = GET_B;
        end
      end
      GET_B: begin
        if (msg_valid && msg_ready_q) begin
          ci_start_d = 1'b1;
          ci_n_d     = N_LOAD;
          ci_dataa_d = a_q;
          ci_datab_d = msg_word;
          state_d    = CALL_LOAD;
        end
      end
      CALL_LOAD: begin
        if (ci.ci_done) begin
          pair_d = pair_q + PAIR_W'(1);
          if (pair_q == PAIR_W'(NUM_PAIRS - 1)) begin
            ci_start_d = 1'b1;
            ci_n_d     = N_START;
            ci_dataa_d = {{(DATA_W - TGT_W){1'b0}}, target_q};
            ci_datab_d = '0;
            state_d    = CALL_START;
          end else begin
            state_d = GET_A;
          end
        end
      end
      CALL_START: begin
        if (ci.ci_done) begin
          gap_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q == CNT_W'(POLL_GAP - 1)) begin
          ci_start_d = 1'b1;
          ci_n_d     = N_POLL;
          state_d    = CALL_POLL;
        end else begin
          gap_d = gap_q + CNT_W'(1);
        end
      end
      CALL_POLL: begin
        if (ci.ci_done) begin
          if (ci.ci_result[0]) begin
            ci_start_d = 1'b1;
            ci_n_d     = N_FETCH;
            state_d    = CALL_FETCH;
          end else begin
            if (poll_q != '1) poll_d = poll_q + CNT_W'(1);
            if ((MAX_POLLS != 0) && (poll_d == CNT_W'(MAX_POLLS))) begin
              timeout_d  = 1'b1;
              ci_start_d = 1'b1;
              ci_n_d     = N_COUNT;
              state_d    = CALL_COUNT;
            end else begin
              gap_d   = '0;
              state_d = GAP;
            end
          end
        end
      end
      CALL_FETCH: begin
        if (ci.ci_done) begin
          collision_d = ci.ci_result;
          found_d     = 1'b1;
          ci_start_d  = 1'b1;
          ci_n_d      = N_COUNT;
          state_d     = CALL_COUNT;
        end
      end
      CALL_COUNT: begin
        if (ci.ci_done) begin
          digests_d      = ci.ci_result;
          result_valid_d = 1'b1;
          state_d        = REPORT;
        end
      end
      REPORT: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Hang watchdog: the outstanding call gets DONE_TIMEOUT cycles including its start cycle.
    if (call_active_c && !ci.ci_done) begin
      if (wait_q == CNT_W'(DONE_TIMEOUT - 1)) begin
        error_d        = 1'b1;
        found_d        = 1'b0;
        result_valid_d = 1'b1;
        state_d        = REPORT;
      end else if (wait_q != '1) begin
        wait_d = wait_q + CNT_W'(1);
      end
    end
    if (ci_start_d) wait_d = '0;

    msg_ready_d = (state_d == GET_A) || (state_d == GET_B);
  end

  assign msg_ready    = msg_ready_q;
  assign ci.ci_start  = ci_start_q;
  assign ci.ci_n      = ci_n_q;
  assign ci.ci_dataa  = ci_dataa_q;
  assign ci.ci_datab  = ci_datab_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign found        = found_q;
  assign timeout      = timeout_q;
  assign error        = error_q;
  assign collision    = collision_q;
  assign digests      = digests_q;

endmodule

// File: tb/tb_collision_sequencer.sv
`timescale 1ns/1ps
module tb_collision_sequencer;

  localparam int NI    = 2;
  localparam int GAP0  = 16;
  localparam int GAP1  = 3;
  localparam int MAXP0 = 0;
  localparam int MAXP1 = 4;
  localparam int DTO   = 255;
  localparam int BUDGET = 3000;

  logic wClock = 1'b0;
  logic clk_en = 1'b1;
  logic reset  = 1'b1;
  always #5 if (clk_en) wClock = ~wClock;

  // Per-instance drive
  logic        go_m    [NI];
  logic [4:0]  tgt_m   [NI];
  logic [31:0] word_m  [NI];
  logic        valid_m [NI];
  // Per-instance observation
  logic        ready_m [NI];
  logic        busy_m  [NI];
  logic        rv_m    [NI];
  logic        found_m [NI];
  logic        tmo_m   [NI];
  logic        err_m   [NI];
  logic [31:0] coll_m  [NI];
  logic [31:0] dig_m   [NI];
  logic        cstart_m[NI];
  logic [2:0]  cn_m    [NI];
  logic [31:0] ca_m    [NI];
  logic [31:0] cb_m    [NI];
  logic        done_m  [NI];
  // Responder configuration and state
  int          lat     [NI];
  int          found_at[NI];
  logic        hang    [NI];
  logic [31:0] coll_v  [NI];
  logic [31:0] dig_v   [NI];
  logic        pend    [NI];
  int          rem     [NI];
  int          polls   [NI];
  logic [2:0]  cap_n   [NI];
  logic [31:0] cap_a   [NI];
  logic [31:0] cap_b   [NI];
  int          viol = 0;
  logic [67:0] log_q[$];     // {instance, n, dataa, datab} per ci_start

  logic [31:0] words [16];
  int n_assert = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    collision_sequencer_if ci ();

    collision_sequencer #(
      .POLL_GAP    ((g == 0) ? GAP0 : GAP1),
      .MAX_POLLS   ((g == 0) ? MAXP0 : MAXP1),
      .DONE_TIMEOUT(DTO)
    ) dut (
      .wClock      (wClock),
      .reset       (reset),
      .go          (go_m[g]),
      .target      (tgt_m[g]),
      .msg_word    (word_m[g]),
      .msg_valid   (valid_m[g]),
      .msg_ready   (ready_m[g]),
      .ci          (ci),
      .busy        (busy_m[g]),
      .result_valid(rv_m[g]),
      .found       (found_m[g]),
      .timeout     (tmo_m[g]),
      .error       (err_m[g]),
      .collision   (coll_m[g]),
      .digests     (dig_m[g])
    );

    assign cstart_m[g]  = ci.ci_start;
    assign cn_m[g]      = ci.ci_n;
    assign ca_m[g]      = ci.ci_dataa;
    assign cb_m[g]      = ci.ci_datab;
    assign done_m[g]    = !hang[g] && ((lat[g] == 0) ? ci.ci_start : (pend[g] && rem[g] == 0));
    assign ci.ci_done   = done_m[g];
    assign ci.ci_result = (ci.ci_n == 3'd3) ? {31'b0, (found_at[g] != 0 && polls[g] + 1 >= found_at[g])} :
                          (ci.ci_n == 3'd2) ? coll_v[g] :
                          (ci.ci_n == 3'd4) ? dig_v[g] : 32'h0;
  end

  // Responder state, call log and protocol watch
  always @(posedge wClock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NI; k++) begin
        pend[k]  <= 1'b0;
        rem[k]   <= 0;
        polls[k] <= 0;
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        if (cstart_m[k]) begin
          if (pend[k]) viol <= viol + 1;
          log_q.push_back({1'(k), cn_m[k], ca_m[k], cb_m[k]});
          cap_n[k] <= cn_m[k];
          cap_a[k] <= ca_m[k];
          cap_b[k] <= cb_m[k];
          if (!done_m[k]) begin
            pend[k] <= 1'b1;
            rem[k]  <= (lat[k] > 0) ? lat[k] - 1 : 0;
          end
        end else if (pend[k]) begin
          if (cn_m[k] !== cap_n[k] || ca_m[k] !== cap_a[k] || cb_m[k] !== cap_b[k]) viol <= viol + 1;
          if (done_m[k]) pend[k] <= 1'b0;
          else if (rem[k] > 0) rem[k] <= rem[k] - 1;
        end
        if (done_m[k] && cn_m[k] == 3'd3) polls[k] <= polls[k] + 1;
        if (done_m[k] && cn_m[k] == 3'd1) polls[k] <= 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reset_check(input string tag);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("%s_busy%0d", tag, k),  32'(busy_m[k]),   32'd0);
      chk($sformatf("%s_rv%0d", tag, k),    32'(rv_m[k]),     32'd0);
      chk($sformatf("%s_found%0d", tag, k), 32'(found_m[k]),  32'd0);
      chk($sformatf("%s_tmo%0d", tag, k),   32'(tmo_m[k]),    32'd0);
      chk($sformatf("%s_err%0d", tag, k),   32'(err_m[k]),    32'd0);
      chk($sformatf("%s_coll%0d", tag, k),  coll_m[k],        32'd0);
      chk($sformatf("%s_dig%0d", tag, k),   dig_m[k],         32'd0);
      chk($sformatf("%s_ready%0d", tag, k), 32'(ready_m[k]),  32'd0);
      chk($sformatf("%s_start%0d", tag, k), 32'(cstart_m[k]), 32'd0);
      chk($sformatf("%s_n%0d", tag, k),     32'(cn_m[k]),     32'd0);
      chk($sformatf("%s_a%0d", tag, k),     ca_m[k],          32'd0);
      chk($sformatf("%s_b%0d", tag, k),     cb_m[k],          32'd0);
    end
  endtask

  // One run on instance k; abort_after >= 0 applies reset once that many words are accepted.
  task automatic run_case(input string tag, input int k, input logic [4:0] t, input int la,
                          input int fa, input logic hg, input int stall_pct, input bit extra_go,
                          input logic [31:0] cv, input logic [31:0] dv, input int abort_after);
    int idx, rv_cyc, base, maxp, gap, np, exp_lat;
    bit exp_found;
    logic [67:0] exp_q[$];
    logic [67:0] e, o;
    lat[k] = la; found_at[k] = fa; hang[k] = hg; coll_v[k] = cv; dig_v[k] = dv;
    base = log_q.size();
    idx = 0; rv_cyc = -1;
    @(negedge wClock);
    tgt_m[k] = t; go_m[k] = 1'b1; valid_m[k] = 1'b0;
    for (int cyc = 1; cyc <= BUDGET; cyc++) begin
      @(negedge wClock);
      go_m[k] = 1'b0;
      if (cyc == 1) chk({tag, "_busy_rise"}, 32'(busy_m[k]), 32'd1);
      if (rv_m[k]) begin rv_cyc = cyc; break; end
      if (abort_after >= 0 && idx == abort_after) begin
        valid_m[k] = 1'b0;
        #2 reset = 1'b1;
        #1 reset_check({tag, "_midrun"});
        @(negedge wClock);
        reset = 1'b0;
        return;
      end
      if (extra_go && busy_m[k] && $urandom_range(0, 7) == 0) begin
        go_m[k] = 1'b1; tgt_m[k] = 5'($urandom);
      end
      if (idx < 16 && $urandom_range(0, 99) >= stall_pct) begin
        valid_m[k] = 1'b1; word_m[k] = words[idx];
      end else begin
        valid_m[k] = 1'b0; word_m[k] = $urandom;
      end
      if (valid_m[k] && ready_m[k]) idx++;
    end
    valid_m[k] = 1'b0;
    chk({tag, "_completed"}, 32'(rv_cyc > 0), 32'd1);

    // Reference outcome from the run rules
    maxp = (k == 0) ? MAXP0 : MAXP1;
    gap  = (k == 0) ? GAP0 : GAP1;
    exp_found = !hg && fa != 0 && (maxp == 0 || fa <= maxp);
    np = (fa != 0 && (maxp == 0 || fa <= maxp)) ? fa : maxp;
    if (hg) exp_lat = 3 + DTO;
    else    exp_lat = 24 + 1 + np * (gap + 1) + (exp_found ? 1 : 0) + 1 + 1;

    if (rv_cyc > 0) begin
      chk({tag, "_found"},   32'(found_m[k]), 32'(exp_found));
      chk({tag, "_timeout"}, 32'(tmo_m[k]),   32'(!hg && !exp_found));
      chk({tag, "_error"},   32'(err_m[k]),   32'(hg));
      chk({tag, "_coll"},    coll_m[k],       exp_found ? cv : 32'd0);
      chk({tag, "_dig"},     dig_m[k],        hg ? 32'd0 : dv);
      if (stall_pct == 0 && (la == 0 || hg)) chk({tag, "_latency"}, 32'(rv_cyc), 32'(exp_lat));
      @(negedge wClock);
      chk({tag, "_rv_pulse"}, 32'(rv_m[k]),   32'd0);
      chk({tag, "_busy_end"}, 32'(busy_m[k]), 32'd0);
    end

    if (hg) exp_q.push_back({1'(k), 3'd0, words[0], words[1]});
    else begin
      for (int i = 0; i < 8; i++) exp_q.push_back({1'(k), 3'd0, words[2*i], words[2*i+1]});
      exp_q.push_back({1'(k), 3'd1, {27'b0, t}, 32'd0});
      for (int i = 0; i < np; i++) exp_q.push_back({1'(k), 3'd3, 64'd0});
      if (exp_found) exp_q.push_back({1'(k), 3'd2, 64'd0});
      exp_q.push_back({1'(k), 3'd4, 64'd0});
    end
    chk({tag, "_ncalls"}, 32'(log_q.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && base + i < log_q.size(); i++) begin
      e = exp_q[i]; o = log_q[base + i];
      chk($sformatf("%s_call%0d_n", tag, i), {28'd0, o[67:64]}, {28'd0, e[67:64]});
      if (e[66:64] <= 3'd1) begin
        chk($sformatf("%s_call%0d_a", tag, i), o[63:32], e[63:32]);
        chk($sformatf("%s_call%0d_b", tag, i), o[31:0],  e[31:0]);
      end
    end
    chk({tag, "_protocol"}, 32'(viol), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NI; k++) begin
      go_m[k] = 1'b0; tgt_m[k] = '0; word_m[k] = '0; valid_m[k] = 1'b0;
      lat[k] = 0; found_at[k] = 1; hang[k] = 1'b0; coll_v[k] = '0; dig_v[k] = '0;
    end
    for (int i = 0; i < 16; i++) words[i] = 32'(i);
    repeat (2) @(negedge wClock);
    reset = 1'b0;
    reset_check("por");

    // Asynchronous reset with the clock stopped, mid-run
    go_m[0] = 1'b1; tgt_m[0] = 5'd9; valid_m[0] = 1'b1; word_m[0] = 32'hA5A5_0001;
    @(negedge wClock);
    go_m[0] = 1'b0;
    repeat (4) @(negedge wClock);
    chk("pre_reset_busy", 32'(busy_m[0]), 32'd1);
    clk_en = 1'b0;
    valid_m[0] = 1'b0;
    #3 reset = 1'b1;
    #1 reset_check("async");
    clk_en = 1'b1;
    repeat (2) @(negedge wClock);
    reset = 1'b0;

    // Directed full run, zero-latency responder
    run_case("full", 0, 5'd5, 0, 4, 1'b0, 0, 1'b0, 32'h0000_1234, 32'h40, -1);
    // Same run with 3-cycle done latency
    run_case("lat3", 0, 5'd5, 3, 4, 1'b0, 0, 1'b0, 32'h0000_1234, 32'h40, -1);
    // Poll limit on the MAX_POLLS=4 instance, never found
    run_case("maxpoll", 1, 5'd17, 0, 0, 1'b0, 0, 1'b0, 32'hDEAD_BEEF, 32'h77, -1);
    // Responder hangs on the first load
    run_case("hang", 0, 5'd3, 0, 1, 1'b1, 0, 1'b0, 32'h1, 32'h2, -1);
    @(negedge wClock);
    chk("hang_idle_busy", 32'(busy_m[0]), 32'd0);
    hang[0] = 1'b0;
    reset = 1'b1;
    @(negedge wClock);
    reset = 1'b0;

    // Reset after 5 words, then a stalled run with ignored go pulses
    for (int i = 0; i < 16; i++) words[i] = 32'h100 + 32'(i);
    run_case("abort", 0, 5'd11, 1, 2, 1'b0, 25, 1'b0, 32'h55, 32'h66, 5);
    run_case("restart", 0, 5'd11, 1, 2, 1'b0, 30, 1'b1, 32'h55, 32'h66, -1);

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      int k;
      k = r % 2;
      for (int i = 0; i < 16; i++) words[i] = $urandom;
      run_case($sformatf("rnd%0d", r), k, 5'($urandom), $urandom_range(0, 3),
               (k == 0) ? $urandom_range(1, 5) : $urandom_range(0, 6), 1'b0,
               (r < 4) ? 0 : 30, 1'(r >= 4), $urandom, $urandom, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
